// File: rtl/acc_vec_if.sv
// Operand/result bus between core_region and the vector engine.
// The core drives the operands and the run request. The engine returns the results and the run status.
interface acc_vec_if #(
    parameter int NWORDS    = 256,
    parameter int IDX_WIDTH = 8
);
    logic                           start_i;
    logic [1:0]                     op_i;
    logic [IDX_WIDTH:0]             len_i;
    logic [NWORDS-1:0][3:0][7:0]    operand_a_i;
    logic [NWORDS-1:0][3:0][7:0]    operand_b_i;
    logic [NWORDS-1:0][3:0][7:0]    result_o;
    logic                           busy_o;
    logic                           done_o;
    logic [IDX_WIDTH:0]             count_o;

    modport master (
        output start_i, op_i, len_i, operand_a_i, operand_b_i,
        input  result_o, busy_o, done_o, count_o
    );

    modport slave (
        input  start_i, op_i, len_i, operand_a_i, operand_b_i,
        output result_o, busy_o, done_o, count_o
    );
endinterface

// File: rtl/acc_vec_engine.sv
// Vector engine: one word per cycle, f(op, A[idx], B[idx]) into a register-held result array.
// Operands are read live, so the producer must keep them stable while busy_o is high.
module acc_vec_engine #(
    parameter int NWORDS    = 256,
    parameter int IDX_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    acc_vec_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [IDX_WIDTH:0] LEN_MAX = (IDX_WIDTH+1)'(NWORDS);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [1:0]                 r_op;
    logic [IDX_WIDTH:0]         r_len;
    logic [IDX_WIDTH-1:0]       r_idx;
    logic [IDX_WIDTH:0]         r_count;
    logic [NWORDS-1:0][31:0]    r_result;

    logic                       w_accept;
    logic [IDX_WIDTH:0]         w_len_clamped;
    logic [IDX_WIDTH:0]         w_count_inc;
    logic                       w_busy;
    logic                       w_done;
    logic [31:0]                w_a;
    logic [31:0]                w_b;
    logic [31:0]                w_wdata;
    logic [NWORDS-1:0]          w_word_we;

    function automatic logic [31:0] f_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [8:0]  s;
        logic [17:0] d;
        r = '0;
        s = '0;
        d = '0;
        case (op)
            2'b00: r = a + b;
            2'b01: begin
                for (int k = 0; k < 4; k++) begin
                    s = {1'b0, a[8*k +: 8]} + {1'b0, b[8*k +: 8]};
                    r[8*k +: 8] = s[8] ? 8'hFF : s[7:0];
                end
            end
            2'b10: begin
                for (int k = 0; k < 4; k++) begin
                    d = d + 18'(16'(a[8*k +: 8]) * 16'(b[8*k +: 8]));
                end
                r = 32'(d);
            end
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    assign w_accept      = (r_state == S_IDLE) && bus.start_i;
    assign w_len_clamped = (bus.len_i > LEN_MAX) ? LEN_MAX : bus.len_i;
    assign w_count_inc   = r_count + 1'b1;
    assign w_a           = bus.operand_a_i[r_idx];
    assign w_b           = bus.operand_b_i[r_idx];
    assign w_wdata       = f_op(r_op, w_a, w_b);

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_we
            assign w_word_we[gi] = w_busy && (r_idx == IDX_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_state_next = (w_len_clamped == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_count_inc == r_len) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Run bookkeeping: idx addresses the word being written, count reports words written so far.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_op    <= bus.op_i;
            r_len   <= w_len_clamped;
            r_idx   <= '0;
            r_count <= '0;
        end else if (w_busy) begin
            r_idx   <= r_idx + 1'b1;
            r_count <= w_count_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else begin
            for (int i = 0; i < NWORDS; i++) begin
                if (w_word_we[i]) begin
                    r_result[i] <= w_wdata;
                end
            end
        end
    end

    assign bus.result_o = r_result;
    assign bus.busy_o   = w_busy;
    assign bus.done_o   = w_done;
    assign bus.count_o  = r_count;
endmodule

// File: tb/tb_acc_vec_engine.sv
// Bench for acc_vec_engine: a timeline model predicts busy/done/count/results every cycle.
// Directed runs add literal expectations for each operation and corner case.
module tb_acc_vec_engine;
    localparam int NWORDS    = 256;
    localparam int IDX_WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    acc_vec_if #(.NWORDS(NWORDS), .IDX_WIDTH(IDX_WIDTH)) u_if ();

    acc_vec_engine #(.NWORDS(NWORDS), .IDX_WIDTH(IDX_WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference operation, written from the arithmetic definitions.
    function automatic logic [31:0] model_f(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sum;
        logic [31:0] r;
        r = 32'd0;
        case (op)
            2'd0: r = a + b;
            2'd1: for (int k = 0; k < 4; k++) begin
                sum = int'(a[8*k +: 8]) + int'(b[8*k +: 8]);
                if (sum > 255) sum = 255;
                r[8*k +: 8] = sum[7:0];
            end
            2'd2: begin
                sum = 0;
                for (int k = 0; k < 4; k++) sum += int'(a[8*k +: 8]) * int'(b[8*k +: 8]);
                r = 32'(sum);
            end
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    // Model: an accepted start at edge c0 with length n writes word k-1 at edge c0+k (k=1..n),
    // shows done after edge c0+n, and can accept again from edge c0+n+2.
    int          cyc     = 0;
    bit          m_valid = 1'b0;
    int          m_c0    = 0;
    int          m_n     = 0;
    logic [1:0]  m_op    = 2'd0;
    logic [31:0] exp_res [NWORDS];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            for (int i = 0; i < NWORDS; i++) exp_res[i] <= 32'd0;
        end else begin
            cyc <= cyc + 1;
            if (m_valid && (cyc + 1 - m_c0) >= 1 && (cyc + 1 - m_c0) <= m_n) begin
                exp_res[cyc - m_c0] <= model_f(m_op, u_if.operand_a_i[cyc - m_c0], u_if.operand_b_i[cyc - m_c0]);
            end
            if (u_if.start_i && (!m_valid || (cyc + 1 - m_c0) >= m_n + 2)) begin
                m_valid <= 1'b1;
                m_c0    <= cyc + 1;
                m_op    <= u_if.op_i;
                m_n     <= (int'(u_if.len_i) > NWORDS) ? NWORDS : int'(u_if.len_i);
            end
        end
    end

    always @(negedge clk) begin
        int k;
        int bad;
        logic [31:0] e_busy, e_done, e_count;
        k       = cyc - m_c0;
        e_busy  = (m_valid && k < m_n) ? 32'd1 : 32'd0;
        e_done  = (m_valid && k == m_n) ? 32'd1 : 32'd0;
        e_count = !m_valid ? 32'd0 : ((k < m_n) ? 32'(k) : 32'(m_n));
        check("cyc_busy", 32'(u_if.busy_o), e_busy);
        check("cyc_done", 32'(u_if.done_o), e_done);
        check("cyc_count", 32'(u_if.count_o), e_count);
        bad = 0;
        for (int i = 0; i < NWORDS; i++) begin
            if (u_if.result_o[i] !== exp_res[i] && bad == 0) bad = i;
        end
        check($sformatf("cyc_result[%0d]", bad), u_if.result_o[bad], exp_res[bad]);
    end

    task automatic start_run(input logic [1:0] op, input int len);
        @(negedge clk);
        u_if.start_i = 1'b1;
        u_if.op_i    = op;
        u_if.len_i   = (IDX_WIDTH+1)'(len);
        @(negedge clk);
        u_if.start_i = 1'b0;
    endtask

    // Called at the first negedge after the start edge; k counts negedges from there.
    task automatic wait_done(input string name, input int k0, output int k_done, output int busy_cyc);
        k_done   = -1;
        busy_cyc = 0;
        for (int k = k0; k < k0 + 400; k++) begin
            if (u_if.done_o) begin
                k_done = k;
                break;
            end
            if (u_if.busy_o) busy_cyc++;
            @(negedge clk);
        end
        if (k_done < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got no done_o, expected one within 400 cycles", name);
        end
    endtask

    task automatic run(input string name, input logic [1:0] op, input int len, output int kd, output int bc);
        start_run(op, len);
        wait_done(name, 0, kd, bc);
        $display("run %s op=%0d len=%0d done_at=%0d busy_cycles=%0d count=%0d",
                 name, op, len, kd, bc, u_if.count_o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kd, bc, dn, first_d, second_d;
        bit hit;
        u_if.start_i     = 1'b0;
        u_if.op_i        = 2'd0;
        u_if.len_i       = '0;
        u_if.operand_a_i = '0;
        u_if.operand_b_i = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        check("model_add_wrap", model_f(2'd0, 32'hFFFFFFFF, 32'h00000001), 32'h00000000);
        check("model_satb", model_f(2'd1, 32'h80FF0110, 32'h80010220), 32'hFFFF0330);
        check("model_dot4_max", model_f(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'h0003F804);

        check("rst_busy", 32'(u_if.busy_o), 32'd0);
        check("rst_done", 32'(u_if.done_o), 32'd0);
        check("rst_count", 32'(u_if.count_o), 32'd0);
        check("rst_result255", u_if.result_o[255], 32'd0);

        // ADD with wrap-around
        for (int i = 0; i < NWORDS; i++) begin
            u_if.operand_a_i[i] = 32'hFFFFFFFF;
            u_if.operand_b_i[i] = 32'(i + 1);
        end
        run("add4", 2'd0, 4, kd, bc);
        check("add_done_at", 32'(kd), 32'd4);
        check("add_busy_cycles", 32'(bc), 32'd4);
        check("add_count", 32'(u_if.count_o), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("add_res%0d", i), u_if.result_o[i], 32'(i));
        check("add_res4_kept", u_if.result_o[4], 32'd0);

        // SATB saturating lanes
        u_if.operand_a_i[0] = 32'h80FF0110;
        u_if.operand_b_i[0] = 32'h80010220;
        run("satb1", 2'd1, 1, kd, bc);
        check("satb_res0", u_if.result_o[0], 32'hFFFF0330);
        check("satb_res1_kept", u_if.result_o[1], 32'd1);

        // DOT4 at max operands and a mixed pair
        u_if.operand_a_i[0] = 32'hFFFFFFFF;
        u_if.operand_b_i[0] = 32'hFFFFFFFF;
        u_if.operand_a_i[1] = 32'h01020304;
        u_if.operand_b_i[1] = 32'h04030201;
        run("dot4", 2'd2, 2, kd, bc);
        check("dot4_res0", u_if.result_o[0], 32'h0003F804);
        check("dot4_res1", u_if.result_o[1], 32'd20);
        check("dot4_res2_kept", u_if.result_o[2], 32'd2);

        // Zero-length run
        run("len0", 2'd3, 0, kd, bc);
        check("len0_done_at", 32'(kd), 32'd0);
        check("len0_busy_cycles", 32'(bc), 32'd0);
        check("len0_count", 32'(u_if.count_o), 32'd0);
        check("len0_res0_kept", u_if.result_o[0], 32'h0003F804);

        // Reset in the middle of a run
        for (int i = 0; i < NWORDS; i++) begin
            u_if.operand_a_i[i] = 32'(3 * i);
            u_if.operand_b_i[i] = 32'd7;
        end
        start_run(2'd0, 10);
        hit = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (u_if.count_o == 9'd5) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!hit) begin
            n_checks++;
            n_errors++;
            $display("FAIL midrst_wait: got count_o=%0d, expected to reach 5", u_if.count_o);
        end
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(u_if.busy_o), 32'd0);
        check("midrst_count", 32'(u_if.count_o), 32'd0);
        check("midrst_res4", u_if.result_o[4], 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            if (u_if.done_o) dn++;
        end
        check("midrst_no_done", 32'(dn), 32'd0);
        $display("run midrst op=0 len=10 aborted at count=5");

        run("xor3", 2'd3, 3, kd, bc);
        check("xor3_count", 32'(u_if.count_o), 32'd3);
        check("xor3_res2", u_if.result_o[2], 32'd1);

        // Over-long length clamps to NWORDS
        for (int i = 0; i < NWORDS; i++) begin
            u_if.operand_a_i[i] = 32'(i);
            u_if.operand_b_i[i] = 32'h00001000;
        end
        run("len300", 2'd0, 300, kd, bc);
        check("len300_done_at", 32'(kd), 32'd256);
        check("len300_count", 32'(u_if.count_o), 32'd256);
        check("len300_res255", u_if.result_o[255], 32'h000010FF);
        check("len300_res0", u_if.result_o[0], 32'h00001000);

        // start_i held high: back-to-back runs
        @(negedge clk);
        u_if.start_i = 1'b1;
        u_if.op_i    = 2'd3;
        u_if.len_i   = 9'd2;
        @(negedge clk);
        dn = 0;
        first_d = -1;
        second_d = -1;
        for (int j = 0; j < 16; j++) begin
            if (u_if.done_o) begin
                dn++;
                if (first_d < 0) first_d = j;
                else if (second_d < 0) second_d = j;
            end
            @(negedge clk);
        end
        u_if.start_i = 1'b0;
        check("held_done_pulses", 32'(dn), 32'd4);
        check("held_done_spacing", 32'(second_d - first_d), 32'd4);
        $display("run held op=3 len=2 done_pulses=%0d spacing=%0d", dn, second_d - first_d);
        repeat (8) @(negedge clk);

        // A start pulse during RUN is ignored
        for (int i = 0; i < NWORDS; i++) begin
            u_if.operand_a_i[i] = 32'hA5A50000 | 32'(i);
            u_if.operand_b_i[i] = 32'h0F0F00F0;
        end
        start_run(2'd3, 6);
        u_if.start_i = 1'b1;
        u_if.op_i    = 2'd0;
        u_if.len_i   = 9'd2;
        @(negedge clk);
        u_if.start_i = 1'b0;
        wait_done("stray", 1, kd, bc);
        $display("run stray op=3 len=6 done_at=%0d count=%0d", kd, u_if.count_o);
        check("stray_done_at", 32'(kd), 32'd6);
        check("stray_count", 32'(u_if.count_o), 32'd6);
        check("stray_res5", u_if.result_o[5], 32'hAAAA00F5);
        repeat (4) @(negedge clk);
        check("stray_idle_after", 32'(u_if.busy_o), 32'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
